// File: rtl/e_mdu_pkg.sv
// Shared constants for the execute-stage multiply/divide unit: mdOp codes,
// FSM state encodings and an issue-decode helper.
package e_mdu_pkg;

    localparam logic [3:0] mdOpNone  = 4'd0;
    localparam logic [3:0] mdOpMult  = 4'd1;
    localparam logic [3:0] mdOpMultu = 4'd2;
    localparam logic [3:0] mdOpDiv   = 4'd3;
    localparam logic [3:0] mdOpDivu  = 4'd4;
    localparam logic [3:0] mdOpMfhi  = 4'd5;
    localparam logic [3:0] mdOpMflo  = 4'd6;
    localparam logic [3:0] mdOpMthi  = 4'd7;
    localparam logic [3:0] mdOpMtlo  = 4'd8;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    function automatic logic isIssueOp(input logic [3:0] op);
        return (op == mdOpMult) || (op == mdOpMultu) ||
               (op == mdOpDiv)  || (op == mdOpDivu);
    endfunction

    function automatic logic isDivOp(input logic [3:0] op);
        return (op == mdOpDiv) || (op == mdOpDivu);
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Execute-stage <-> MDU bundle: op/operand request side and HI/LO/busy response side.
interface e_mdu_if #(parameter int WIDTH = 32);

    logic [3:0]       mdOp;
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mdOut;

    modport master (
        output mdOp, start, flush, srcA, srcB,
        input  busy, hi, lo, mdOut
    );

    modport slave (
        input  mdOp, start, flush, srcA, srcB,
        output busy, hi, lo, mdOut
    );

endinterface

// File: rtl/e_mdu_calc.sv
// Combinational product/quotient/remainder. resWr is low for a divide by zero
// so the caller leaves HI/LO untouched at completion.
module e_mdu_calc
    import e_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] resHi,
    output logic [WIDTH-1:0] resLo,
    output logic             resWr
);

    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2*WIDTH-1:0] sProd;
    logic [2*WIDTH-1:0] uProd;
    logic               divZero;
    logic               divOvf;
    logic [WIDTH-1:0]   sDivisor;
    logic [WIDTH-1:0]   uDivisor;
    logic [WIDTH-1:0]   sQuo, sRem, uQuo, uRem;

    assign sProd = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign uProd = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign divZero = (b == '0);
    assign divOvf  = (a == MIN) && (b == '1);

    // MIN / -1 overflows; dividing by +1 instead yields exactly LO = MIN, HI = 0.
    assign sDivisor = (divZero || divOvf) ? ONE : b;
    assign uDivisor = divZero ? ONE : b;

    assign sQuo = $signed(a) / $signed(sDivisor);
    assign sRem = $signed(a) % $signed(sDivisor);
    assign uQuo = a / uDivisor;
    assign uRem = a % uDivisor;

    always_comb begin
        resHi = '0;
        resLo = '0;
        resWr = 1'b0;
        case (op)
            mdOpMult:  begin {resHi, resLo} = sProd; resWr = 1'b1; end
            mdOpMultu: begin {resHi, resLo} = uProd; resWr = 1'b1; end
            mdOpDiv:   begin resHi = sRem; resLo = sQuo; resWr = ~divZero; end
            mdOpDivu:  begin resHi = uRem; resLo = uQuo; resWr = ~divZero; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at issue
// into staging registers and committed when the latency counter expires.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    reset,
    e_mdu_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hiReg, loReg;
    logic [WIDTH-1:0] resHi, resLo;
    logic             resWr;

    logic [WIDTH-1:0] calcHi, calcLo;
    logic             calcWr;
    logic             issue;

    e_mdu_calc #(.WIDTH(WIDTH)) uCalc (
        .op    (bus.mdOp),
        .a     (bus.srcA),
        .b     (bus.srcB),
        .resHi (calcHi),
        .resLo (calcLo),
        .resWr (calcWr)
    );

    assign issue = bus.start && !bus.flush && (state == IDLE) && isIssueOp(bus.mdOp);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hiReg <= '0;
            loReg <= '0;
            resHi <= '0;
            resLo <= '0;
            resWr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state <= BUSY;
                        cnt   <= isDivOp(bus.mdOp) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        resHi <= calcHi;
                        resLo <= calcLo;
                        resWr <= calcWr;
                    end else if (!bus.flush) begin
                        if (bus.mdOp == mdOpMthi) hiReg <= bus.srcA;
                        if (bus.mdOp == mdOpMtlo) loReg <= bus.srcA;
                    end
                end
                BUSY: begin
                    // flush is deliberately ignored here: the op already committed
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                        if (resWr) begin
                            hiReg <= resHi;
                            loReg <= resLo;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = (state == BUSY);
    assign bus.hi    = hiReg;
    assign bus.lo    = loReg;
    assign bus.mdOut = (bus.mdOp == mdOpMfhi) ? hiReg :
                       (bus.mdOp == mdOpMflo) ? loReg : '0;

endmodule

// File: doc/e_mdu.md
# e_mdu

Multi-cycle multiply/divide unit for the execute stage of the pipelined MIPS core. It sits beside the combinational execute ALU and owns the HI/LO register pair. It executes mult/multu/div/divu with a configurable cycle latency, and handles mthi/mtlo/mfhi/mflo. A `busy` output lets hazard control stall later HI/LO consumers.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: busy cycles for mult/multu. Must be ≥1.
- `DIV_CYCLES`, 10: busy cycles for div/divu. Must be ≥1.
- `clk  in  1`: single clock. Every register updates on the rising edge.
- `reset  in  1`: synchronous, active-high.
- `mdOp  in  4`: operation code (encodings in `const.v`, see Structure).
- `start  in  1`: qualifies mult/multu/div/divu for issue. Ignored for other ops.
- `flush  in  1`: exception/interrupt cancel for the instruction currently in E.
- `srcA  in  WIDTH`: rs operand (dividend / multiplicand / mthi-mtlo data).
- `srcB  in  WIDTH`: rt operand (divisor / multiplier).
- `busy  out  1`: high while an operation is in flight.
- `hi  out  WIDTH`: current HI register.
- `lo  out  WIDTH`: current LO register.
- `mdOut  out  WIDTH`: `hi` when mdOp = MFHI, `lo` when mdOp = MFLO, else 0. Combinational.

## Operation
- Reset: state IDLE; counter = 0; `busy` = 0; HI = 0; LO = 0; result staging registers = 0.
- FSM states:
  - IDLE. Transition to BUSY on an issue: `start & ~flush & ~busy` with mdOp ∈ {MULT, MULTU, DIV, DIVU}.
  - BUSY. Return to IDLE when the counter reaches 1.
- Issue cycle:
  - Latch the operands.
  - Compute the result into staging registers (`resHi`, `resLo`).
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
- BUSY: the counter decrements each cycle. On the cycle where the counter = 1, staging is written to HI/LO and the FSM returns to IDLE.
- Arithmetic:
  - MULT: {HI,LO} = signed 2·WIDTH-bit product.
  - MULTU: {HI,LO} = unsigned 2·WIDTH-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder carrying the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV with srcA = MIN and srcB = −1: LO = MIN, HI = 0.
  - Divide by zero (DIV/DIVU, srcB = 0): the unit still goes busy for DIV_CYCLES; HI/LO are left unchanged at completion.
- MTHI/MTLO:
  - In IDLE without flush, the write of srcA to HI or LO takes effect at the next edge, with no busy period.
  - While busy or under flush, the write is ignored.
- Issue while busy: ignored. Hazard control must stall, so this never happens legally.
- Flush:
  - Suppresses issue and mt writes in that same cycle.
  - Flush during BUSY does not abort. The already-committed operation completes, as MIPS requires.
- Reset mid-operation: returns to IDLE immediately, `busy` = 0, HI/LO = 0. The result is discarded.

## Timing
- Issue at edge T0 (start sampled high). `busy` = 1 from after T0 for exactly N cycles, where N is the op latency.
- HI/LO hold their new values after edge T0+N. On that same edge `busy` falls.
- A back-to-back issue is accepted in the first cycle after `busy` falls.
- mfhi issued in the cycle `busy` = 0 reads the new value through `mdOut`.
- `mdOut` and `busy` are never functions of `start`. `busy` is a registered output; stall logic ORs in `start` externally.
- mthi at edge T: `hi` shows the new value after T.

## Structure
- Add to `const.v`, 4-bit `mdOp` codes:
  - `mdOpNone` = 0
  - `mdOpMult` = 1, `mdOpMultu` = 2, `mdOpDiv` = 3, `mdOpDivu` = 4
  - `mdOpMfhi` = 5, `mdOpMflo` = 6, `mdOpMthi` = 7, `mdOpMtlo` = 8
- Add to `const.v`: state encodings IDLE = 0, BUSY = 1.
- One natural sub-module, `e_mdu_calc`: combinational product/quotient/remainder including the MIN/−1 and zero cases.
- The FSM, counter and HI/LO registers stay in `e_mdu`.
- Counter width: $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).

## Test plan
- Reset then MULT, srcA = 0xFFFFFFFE (−2), srcB = 3 → `busy` high for 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
- MULTU, 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001 after 5 cycles.
- DIV, −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF after 10 cycles. DIVU, 7 / 0 → busy 10 cycles, HI/LO unchanged.
- MTLO 0x1234 in IDLE → `lo` = 0x1234 next cycle. Then MFLO → `mdOut` = 0x1234. MTHI issued while busy → HI unaffected.
- MULT with `start` = 1 and `flush` = 1 → `busy` stays 0, HI/LO unchanged. Flush asserted during BUSY → operation completes normally.
- Reset asserted in cycle 3 of a DIV → next cycle `busy` = 0, HI = LO = 0. A new MULT issued right after completes with the correct result.
